// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit beside the EX-stage ALU. It runs a 32-step shift-add
// multiply or restoring divide on operand magnitudes, fixes the signs, and owns HI/LO.
module mdu_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [CW-1:0] r_cnt;
  logic          r_is_div;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_dbz;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_acc;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_done;
  logic          r_dbz_pulse;

  logic          w_idle;
  logic          w_accept;
  logic          w_last;
  logic          w_signed;
  logic          w_rs_neg;
  logic          w_rt_neg;
  logic [31:0]   w_rs_mag;
  logic [31:0]   w_rt_mag;
  logic          w_start_dbz;
  logic [32:0]   w_mul_sum;
  logic [32:0]   w_div_shift;
  logic          w_div_ge;
  logic [31:0]   w_div_diff;
  logic [63:0]   w_prod;
  logic [63:0]   w_prod_fix;
  logic [31:0]   w_quot_fix;
  logic [31:0]   w_rem_fix;
  logic          w_commit;

  assign w_idle      = (r_state == S_IDLE);
  assign w_accept    = w_idle & start & ~flush;
  assign w_last      = (r_cnt == CW'(ITER - 1));
  assign w_signed    = ~op[0];
  assign w_rs_neg    = w_signed & rs_data[31];
  assign w_rt_neg    = w_signed & rt_data[31];
  assign w_rs_mag    = w_rs_neg ? -rs_data : rs_data;
  assign w_rt_mag    = w_rt_neg ? -rt_data : rt_data;
  assign w_start_dbz = op[1] & (rt_data == 32'd0);

  // Multiply: r_acc is the running high half, r_b shifts out multiplier bits into the low half.
  assign w_mul_sum   = r_b[0] ? ({1'b0, r_acc} + {1'b0, r_a}) : {1'b0, r_acc};

  // Divide: r_acc is the partial remainder, r_b shifts dividend bits out and quotient bits in.
  assign w_div_shift = {r_acc, r_b[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_a});
  assign w_div_diff  = w_div_shift[31:0] - r_a;

  assign w_prod      = {r_acc, r_b};
  assign w_prod_fix  = r_neg_q ? -w_prod : w_prod;
  assign w_quot_fix  = r_neg_q ? -r_b : r_b;
  assign w_rem_fix   = r_neg_r ? -r_acc : r_acc;

  assign w_commit    = (r_state == S_FIX) & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_start_dbz ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          w_state_next = S_IDLE;
        end else if (w_last) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= op[1];
      r_neg_q  <= w_rs_neg ^ w_rt_neg;
      r_neg_r  <= op[1] & w_rs_neg;
      r_dbz    <= w_start_dbz;
      r_a      <= op[1] ? w_rt_mag : w_rs_mag;
      r_b      <= (op[1] && !w_start_dbz) ? w_rs_mag : (op[1] ? 32'd0 : w_rt_mag);
      // A zero divisor parks the raw dividend in r_acc so FIX can return it in HI.
      r_acc    <= w_start_dbz ? rs_data : 32'd0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_is_div) begin
        r_acc <= w_div_ge ? w_div_diff : w_div_shift[31:0];
        r_b   <= {r_b[30:0], w_div_ge};
      end else begin
        r_acc <= w_mul_sum[32:1];
        r_b   <= {w_mul_sum[0], r_b[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi        <= '0;
      r_lo        <= '0;
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
    end else begin
      r_done      <= w_commit;
      r_dbz_pulse <= w_commit & r_dbz;
      if (w_commit) begin
        if (r_dbz) begin
          r_hi <= r_acc;
          r_lo <= 32'hFFFF_FFFF;
        end else if (r_is_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quot_fix;
        end else begin
          r_hi <= w_prod_fix[63:32];
          r_lo <= w_prod_fix[31:0];
        end
      end else if (w_idle && !start) begin
        if (hi_we) begin
          r_hi <= wdata;
        end
        if (lo_we) begin
          r_lo <= wdata;
        end
      end
    end
  end

  assign busy        = (r_state == S_RUN) | (r_state == S_FIX);
  assign stall       = busy | w_accept;
  assign done        = r_done;
  assign div_by_zero = r_dbz_pulse;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
